// File: rtl/fft_result_capture.sv
// Captures one FFT result frame into a block RAM and replays it on a flow-controlled
// AXI4-Stream master, latching the block exponent and flagging length/overrun faults.
module fft_result_capture #(
    parameter int LOG2_FFT_LEN  = 11,
    parameter int DATAOUT_WIDTH = 16,
    parameter int USER_WIDTH    = 16
) (
    input  logic                       i_aclk,
    input  logic                       i_rst,
    input  logic                       i_aclken,
    input  logic                       i_arm,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [2*DATAOUT_WIDTH-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]      i_axi4s_data_tuser,
    output logic                       o_axi4s_data_tvalid,
    output logic [2*DATAOUT_WIDTH-1:0] o_axi4s_data_tdata,
    output logic                       o_axi4s_data_tlast,
    input  logic                       i_axi4s_data_tready,
    output logic [7:0]                 o_blk_exp,
    output logic                       o_busy,
    output logic                       o_len_err,
    output logic                       o_ovf
);

    localparam int N  = 1 << LOG2_FFT_LEN;
    localparam int AW = LOG2_FFT_LEN;
    localparam int DW = 2 * DATAOUT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

    state_t          state_reg;
    logic            sof_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic            rd_done_reg;
    logic [7:0]      blk_exp_reg;
    logic            len_err_reg;
    logic            ovf_reg;

    logic [DW-1:0]   ram [0:N-1];
    logic [DW-1:0]   ram_q_reg;
    logic            rd_valid_reg;
    logic            rd_last_reg;

    logic [DW-1:0]   skid_data_reg [0:1];
    logic            skid_last_reg [0:1];
    logic [1:0]      skid_cnt_reg;

    logic            in_beat;
    logic            cap_first;
    logic            cap_next;
    logic            wr_en;
    logic [AW-1:0]   wr_addr_next;
    logic            wr_at_end;
    logic            cap_end;
    logic            cap_bad;

    logic            out_valid;
    logic [DW-1:0]   head_data;
    logic            head_last;
    logic            pop;
    logic            pop_skid;
    logic            push;
    logic            push_to_1;
    logic            rd_issue;

    logic            unused_tuser;

    assign unused_tuser = ^i_axi4s_data_tuser[USER_WIDTH-1:8];

    // Input side: every beat is qualified by the clock enable.
    assign in_beat      = i_aclken & i_axi4s_data_tvalid;
    assign cap_first    = (state_reg == S_ARMED) & in_beat & sof_reg;
    assign cap_next     = (state_reg == S_CAPTURE) & in_beat;
    assign wr_en        = cap_first | cap_next;
    assign wr_addr_next = cap_first ? '0 : wr_addr_reg + 1'b1;
    assign wr_at_end    = (wr_addr_next == {AW{1'b1}});
    assign cap_end      = wr_en & (i_axi4s_data_tlast | wr_at_end);
    assign cap_bad      = wr_en & (i_axi4s_data_tlast ^ wr_at_end);

    // Output head is the oldest skid entry, or the RAM read data arriving this cycle.
    assign out_valid = (skid_cnt_reg != 2'd0) | rd_valid_reg;
    assign head_data = (skid_cnt_reg != 2'd0) ? skid_data_reg[0] : ram_q_reg;
    assign head_last = (skid_cnt_reg != 2'd0) ? skid_last_reg[0] : rd_last_reg;
    assign pop       = out_valid & i_axi4s_data_tready;
    assign pop_skid  = pop & (skid_cnt_reg != 2'd0);
    assign push      = rd_valid_reg & ~(pop & (skid_cnt_reg == 2'd0));
    assign push_to_1 = ((skid_cnt_reg - {1'b0, pop_skid}) == 2'd1);

    // A read may only launch if its data is guaranteed a skid slot when it lands.
    assign rd_issue = (state_reg == S_READOUT) & ~rd_done_reg &
                      (({1'b0, skid_cnt_reg} + {2'b0, rd_valid_reg}) <= (3'd1 + {2'b0, pop}));

    assign o_axi4s_data_tvalid = out_valid;
    assign o_axi4s_data_tdata  = out_valid ? head_data : '0;
    assign o_axi4s_data_tlast  = out_valid & head_last;
    assign o_blk_exp           = blk_exp_reg;
    assign o_busy              = (state_reg != S_IDLE);
    assign o_len_err           = len_err_reg;
    assign o_ovf               = ovf_reg;

    always_ff @(posedge i_aclk) begin
        if (wr_en) begin
            ram[wr_addr_next] <= i_axi4s_data_tdata;
        end
        if (rd_issue) begin
            ram_q_reg <= ram[rd_addr_reg];
        end
    end

    always_ff @(posedge i_aclk) begin
        if (pop_skid) begin
            skid_data_reg[0] <= skid_data_reg[1];
            skid_last_reg[0] <= skid_last_reg[1];
        end
        if (push) begin
            if (push_to_1) begin
                skid_data_reg[1] <= ram_q_reg;
                skid_last_reg[1] <= rd_last_reg;
            end else begin
                skid_data_reg[0] <= ram_q_reg;
                skid_last_reg[0] <= rd_last_reg;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            sof_reg      <= 1'b1;
            wr_addr_reg  <= '0;
            rd_addr_reg  <= '0;
            rd_done_reg  <= 1'b0;
            blk_exp_reg  <= 8'd0;
            len_err_reg  <= 1'b0;
            ovf_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            skid_cnt_reg <= 2'd0;
        end else begin
            if (in_beat) begin
                sof_reg <= i_axi4s_data_tlast;
            end
            rd_valid_reg <= rd_issue;
            skid_cnt_reg <= skid_cnt_reg - {1'b0, pop_skid} + {1'b0, push};
            if (rd_issue) begin
                rd_last_reg <= (rd_addr_reg == {AW{1'b1}});
                rd_addr_reg <= rd_addr_reg + 1'b1;
                if (rd_addr_reg == {AW{1'b1}}) begin
                    rd_done_reg <= 1'b1;
                end
            end
            if (cap_bad) begin
                len_err_reg <= 1'b1;
            end
            if (wr_en) begin
                wr_addr_reg <= wr_addr_next;
            end
            if (cap_end) begin
                rd_addr_reg <= '0;
                rd_done_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (i_arm) begin
                        len_err_reg <= 1'b0;
                        ovf_reg     <= 1'b0;
                        state_reg   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (cap_first) begin
                        blk_exp_reg <= i_axi4s_data_tuser[7:0];
                        state_reg   <= cap_end ? S_READOUT : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_end) begin
                        state_reg <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (in_beat & sof_reg) begin
                        ovf_reg <= 1'b1;
                    end
                    if (pop & head_last) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_capture.sv
// Directed bench for fft_result_capture with an 8-sample frame; each scenario task
// drives its stimulus and compares against hand-derived expectations.
module tb_fft_result_capture;

    localparam int L  = 3;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int UW = 16;

    logic            i_aclk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_aclken = 1'b0;
    logic            i_arm = 1'b0;
    logic            i_axi4s_data_tvalid = 1'b0;
    logic [2*DW-1:0] i_axi4s_data_tdata = '0;
    logic            i_axi4s_data_tlast = 1'b0;
    logic [UW-1:0]   i_axi4s_data_tuser = '0;
    logic            o_axi4s_data_tvalid;
    logic [2*DW-1:0] o_axi4s_data_tdata;
    logic            o_axi4s_data_tlast;
    logic            i_axi4s_data_tready = 1'b0;
    logic [7:0]      o_blk_exp;
    logic            o_busy;
    logic            o_len_err;
    logic            o_ovf;

    int checks = 0;
    int failures = 0;

    fft_result_capture #(
        .LOG2_FFT_LEN (L),
        .DATAOUT_WIDTH(DW),
        .USER_WIDTH   (UW)
    ) dut (
        .i_aclk             (i_aclk),
        .i_rst              (i_rst),
        .i_aclken           (i_aclken),
        .i_arm              (i_arm),
        .i_axi4s_data_tvalid(i_axi4s_data_tvalid),
        .i_axi4s_data_tdata (i_axi4s_data_tdata),
        .i_axi4s_data_tlast (i_axi4s_data_tlast),
        .i_axi4s_data_tuser (i_axi4s_data_tuser),
        .o_axi4s_data_tvalid(o_axi4s_data_tvalid),
        .o_axi4s_data_tdata (o_axi4s_data_tdata),
        .o_axi4s_data_tlast (o_axi4s_data_tlast),
        .i_axi4s_data_tready(i_axi4s_data_tready),
        .o_blk_exp          (o_blk_exp),
        .o_busy             (o_busy),
        .o_len_err          (o_len_err),
        .o_ovf              (o_ovf)
    );

    always #5 i_aclk = ~i_aclk;

    // Transfer recorder and stall-stability watcher, sampled on the falling edge.
    logic [31:0] xq_data[$];
    logic        xq_last[$];
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge i_aclk) begin
        if (prev_stall && (!o_axi4s_data_tvalid || o_axi4s_data_tdata !== prev_data ||
                           o_axi4s_data_tlast !== prev_last))
            stall_viol <= stall_viol + 1;
        prev_stall <= o_axi4s_data_tvalid & ~i_axi4s_data_tready;
        prev_data  <= o_axi4s_data_tdata;
        prev_last  <= o_axi4s_data_tlast;
        if (o_axi4s_data_tvalid && i_axi4s_data_tready) begin
            xq_data.push_back(o_axi4s_data_tdata);
            xq_last.push_back(o_axi4s_data_tlast);
            $display("xfer %0d data=%h last=%b", xq_data.size() - 1, o_axi4s_data_tdata,
                     o_axi4s_data_tlast);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int tag, input int a);
        return {16'(tag * 256 + a), 16'(a)};
    endfunction

    function automatic logic [31:0] got_data(input int idx);
        if (idx < xq_data.size()) return xq_data[idx];
        return 'x;
    endfunction

    function automatic logic got_last(input int idx);
        if (idx < xq_last.size()) return xq_last[idx];
        return 1'bx;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) begin
            @(posedge i_aclk);
            #1;
        end
        i_rst = 1'b0;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        @(posedge i_aclk);
        #1;
        i_arm = 1'b0;
    endtask

    // Gap cycles present a tempting beat (tvalid and tlast high) with the enable low.
    task automatic drive_beat(input logic [31:0] d, input logic last, input logic [15:0] user,
                              input int gap, input logic arm_now);
        for (int g = 0; g < gap; g++) begin
            i_aclken = 1'b0;
            i_axi4s_data_tvalid = 1'b1;
            i_axi4s_data_tdata = 32'hDEAD_BEEF;
            i_axi4s_data_tlast = 1'b1;
            i_axi4s_data_tuser = 16'hFFFF;
            @(posedge i_aclk);
            #1;
        end
        i_aclken = 1'b1;
        i_axi4s_data_tvalid = 1'b1;
        i_axi4s_data_tdata = d;
        i_axi4s_data_tlast = last;
        i_axi4s_data_tuser = user;
        i_arm = arm_now;
        @(posedge i_aclk);
        #1;
        i_aclken = 1'b0;
        i_axi4s_data_tvalid = 1'b0;
        i_axi4s_data_tlast = 1'b0;
        i_arm = 1'b0;
    endtask

    task automatic send_frame(input int tag, input int first, input int n, input int last_at,
                              input int gap, input int blk);
        for (int a = first; a < n; a++)
            drive_beat(mk(tag, a), (a == last_at), {8'(a), 8'(blk + a)}, gap, 1'b0);
    endtask

    task automatic wait_xfers(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_aclk);
            #1;
            if (xq_data.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge i_aclk);
        checks++;
        if (o_axi4s_data_tvalid !== 1'b0 || o_axi4s_data_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got tvalid=%b tlast=%b expected 0/0",
                     o_axi4s_data_tvalid, o_axi4s_data_tlast);
        end
        checks++;
        if (o_axi4s_data_tdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_tdata got %h expected 0", o_axi4s_data_tdata);
        end
        checks++;
        if (o_busy !== 1'b0 || o_len_err !== 1'b0 || o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got busy=%b len_err=%b ovf=%b expected 0/0/0",
                     o_busy, o_len_err, o_ovf);
        end
        checks++;
        if (o_blk_exp !== 8'h00) begin
            failures++;
            $display("FAIL reset_blk_exp got %h expected 00", o_blk_exp);
        end
    endtask

    task automatic test_normal();
        int base;
        bit ok;
        base = xq_data.size();
        i_axi4s_data_tready = 1'b1;
        arm();
        @(negedge i_aclk);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL normal_busy_rise got %b expected 1", o_busy);
        end
        send_frame(1, 0, 8, 7, 2, 8'h30);
        @(negedge i_aclk);
        checks++;
        if (o_axi4s_data_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL normal_latency_early got tvalid=%b expected 0", o_axi4s_data_tvalid);
        end
        @(negedge i_aclk);
        checks++;
        if (o_axi4s_data_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL normal_latency got tvalid=%b expected 1", o_axi4s_data_tvalid);
        end
        wait_xfers(base + 8, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL normal_timeout got %0d transfers expected 8", xq_data.size() - base);
        end
        repeat (3) @(negedge i_aclk);
        checks++;
        if (xq_data.size() != base + 8 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL normal_count got %0d transfers busy=%b expected 8 busy=0",
                     xq_data.size() - base, o_busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(1, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL normal_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(1, i), (i == 7));
            end
        end
        checks++;
        if (o_len_err !== 1'b0 || o_blk_exp !== 8'h30) begin
            failures++;
            $display("FAIL normal_status got len_err=%b blk_exp=%h expected 0/30",
                     o_len_err, o_blk_exp);
        end
    endtask

    task automatic test_arm_mid_frame();
        int base;
        bit ok;
        base = xq_data.size();
        i_axi4s_data_tready = 1'b1;
        for (int a = 0; a < 8; a++)
            drive_beat(mk(2, a), (a == 7), {8'(a), 8'(8'h40 + a)}, 0, (a == 3));
        send_frame(3, 0, 8, 7, 0, 8'h50);
        wait_xfers(base + 8, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midarm_timeout got %0d transfers expected 8", xq_data.size() - base);
        end
        repeat (3) @(negedge i_aclk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(3, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL midarm_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(3, i), (i == 7));
            end
        end
        checks++;
        if (o_blk_exp !== 8'h50 || xq_data.size() != base + 8) begin
            failures++;
            $display("FAIL midarm_status got blk_exp=%h count=%0d expected 50/8", o_blk_exp,
                     xq_data.size() - base);
        end
    endtask

    task automatic test_short_frame();
        int base;
        bit ok;
        logic [31:0] exp_d;
        base = xq_data.size();
        arm();
        send_frame(4, 0, 5, 4, 0, 8'h60);
        @(negedge i_aclk);
        checks++;
        if (o_len_err !== 1'b1) begin
            failures++;
            $display("FAIL short_len_err got %b expected 1", o_len_err);
        end
        wait_xfers(base + 8, 50, ok);
        repeat (3) @(negedge i_aclk);
        checks++;
        if (!ok || xq_data.size() != base + 8) begin
            failures++;
            $display("FAIL short_count got %0d transfers expected 8", xq_data.size() - base);
        end
        // Addresses 5..7 still hold the previous frame.
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 5) ? mk(4, i) : mk(3, i);
            checks++;
            if (got_data(base + i) !== exp_d || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL short_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), exp_d, (i == 7));
            end
        end
    endtask

    task automatic test_long_frame();
        int base;
        bit ok;
        base = xq_data.size();
        arm();
        @(negedge i_aclk);
        checks++;
        if (o_len_err !== 1'b0) begin
            failures++;
            $display("FAIL long_arm_clear got len_err=%b expected 0", o_len_err);
        end
        send_frame(5, 0, 8, -1, 0, 8'h70);
        @(negedge i_aclk);
        checks++;
        if (o_len_err !== 1'b1) begin
            failures++;
            $display("FAIL long_len_err got %b expected 1", o_len_err);
        end
        wait_xfers(base + 8, 50, ok);
        repeat (3) @(negedge i_aclk);
        checks++;
        if (!ok || xq_data.size() != base + 8 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL long_count got %0d transfers busy=%b expected 8/0",
                     xq_data.size() - base, o_busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(5, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL long_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(5, i), (i == 7));
            end
        end
        // The unterminated frame leaves sof low; one tlast beat re-aligns frame tracking.
        drive_beat(32'h0, 1'b1, 16'h0, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        int base;
        int viol0;
        bit ok;
        base = xq_data.size();
        viol0 = stall_viol;
        i_axi4s_data_tready = 1'b0;
        arm();
        send_frame(6, 0, 8, 7, 0, 8'h80);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            i_axi4s_data_tready = ($urandom_range(0, 9) < 3);
            @(negedge i_aclk);
            #1;
            if (xq_data.size() >= base + 8) begin
                ok = 1'b1;
                break;
            end
            @(posedge i_aclk);
            #1;
        end
        @(posedge i_aclk);
        #1;
        i_axi4s_data_tready = 1'b0;
        repeat (4) @(negedge i_aclk);
        checks++;
        if (!ok || xq_data.size() != base + 8 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_count got %0d transfers busy=%b expected 8/0",
                     xq_data.size() - base, o_busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(6, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL bp_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(6, i), (i == 7));
            end
        end
        checks++;
        if (stall_viol != viol0) begin
            failures++;
            $display("FAIL bp_stall_stable got %0d violations expected 0", stall_viol - viol0);
        end
    endtask

    task automatic test_overrun();
        int base;
        int viol0;
        bit ok;
        base = xq_data.size();
        viol0 = stall_viol;
        i_axi4s_data_tready = 1'b0;
        arm();
        send_frame(7, 0, 8, 7, 0, 8'h90);
        repeat (4) @(negedge i_aclk);
        checks++;
        if (o_ovf !== 1'b0 || o_axi4s_data_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_before got ovf=%b tvalid=%b expected 0/1", o_ovf,
                     o_axi4s_data_tvalid);
        end
        @(posedge i_aclk);
        #1;
        drive_beat(mk(8, 0), 1'b0, 16'h00A0, 0, 1'b0);
        @(negedge i_aclk);
        checks++;
        if (o_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag got %b expected 1", o_ovf);
        end
        send_frame(8, 1, 8, 7, 0, 8'hA0);
        i_axi4s_data_tready = 1'b1;
        wait_xfers(base + 8, 50, ok);
        repeat (3) @(negedge i_aclk);
        checks++;
        if (!ok || xq_data.size() != base + 8 || o_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_count got %0d transfers ovf=%b expected 8/1",
                     xq_data.size() - base, o_ovf);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(7, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL ovf_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(7, i), (i == 7));
            end
        end
        checks++;
        if (stall_viol != viol0) begin
            failures++;
            $display("FAIL ovf_stall_stable got %0d violations expected 0", stall_viol - viol0);
        end
    endtask

    task automatic test_reset_mid_readout();
        int base;
        bit ok;
        base = xq_data.size();
        i_axi4s_data_tready = 1'b1;
        arm();
        @(negedge i_aclk);
        checks++;
        if (o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_arm_clear got ovf=%b expected 0", o_ovf);
        end
        send_frame(9, 0, 8, 7, 0, 8'hB0);
        wait_xfers(base + 4, 50, ok);
        @(posedge i_aclk);
        #1;
        i_rst = 1'b1;
        @(posedge i_aclk);
        #1;
        i_rst = 1'b0;
        @(negedge i_aclk);
        checks++;
        if (!ok || o_axi4s_data_tvalid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort got tvalid=%b busy=%b expected 0/0", o_axi4s_data_tvalid,
                     o_busy);
        end
        repeat (3) @(negedge i_aclk);
        base = xq_data.size();
        arm();
        send_frame(10, 0, 8, 7, 0, 8'hC0);
        wait_xfers(base + 8, 50, ok);
        repeat (3) @(negedge i_aclk);
        checks++;
        if (!ok || xq_data.size() != base + 8 || o_blk_exp !== 8'hC0) begin
            failures++;
            $display("FAIL rst_refill got %0d transfers blk_exp=%h expected 8/C0",
                     xq_data.size() - base, o_blk_exp);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data(base + i) !== mk(10, i) || got_last(base + i) !== (i == 7)) begin
                failures++;
                $display("FAIL rst_beat%0d got %h/%b expected %h/%b", i, got_data(base + i),
                         got_last(base + i), mk(10, i), (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_arm_mid_frame();
        test_short_frame();
        test_long_frame();
        test_back_pressure();
        test_overrun();
        test_reset_mid_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_result_capture.md
# fft_result_capture

Captures one complete FFT output frame from the core's result AXI4-Stream (no back-pressure on that side) into an internal buffer of 2^LOG2_FFT_LEN complex samples. It then replays the frame on a flow-controlled AXI4-Stream master toward a slow host-side consumer such as a UART or debug bridge. The block sits at the receiving end of the FFT core's output interface, in parallel with the on-board frame checker. It also records the frame's block exponent and flags length and overrun faults.

## Interface
- LOG2_FFT_LEN, 11, log2 of frame length N; legal range 3..16
- DATAOUT_WIDTH, 16, byte-padded width of one real/imag component
- USER_WIDTH, 16, input tuser width; bits [7:0] carry blk_exp
- i_aclk  in  1  single clock for the whole block
- i_rst  in  1  synchronous, active-high reset
- i_aclken  in  1  qualifies every input-side beat; a beat is accepted only when i_aclken & i_axi4s_data_tvalid
- i_arm  in  1  single-cycle pulse requesting capture of the next full frame
- i_axi4s_data_tvalid  in  1  FFT result valid
- i_axi4s_data_tdata  in  2*DATAOUT_WIDTH  {imag, real}
- i_axi4s_data_tlast  in  1  last sample of the FFT frame
- i_axi4s_data_tuser  in  USER_WIDTH  {index, blk_exp}
- o_axi4s_data_tvalid  out  1  replay beat valid
- o_axi4s_data_tdata  out  2*DATAOUT_WIDTH  replayed sample
- o_axi4s_data_tlast  out  1  high on replay beat N-1
- i_axi4s_data_tready  in  1  consumer ready
- o_blk_exp  out  8  tuser[7:0] latched from the first captured beat
- o_busy  out  1  high in ARMED, CAPTURE and READOUT
- o_len_err  out  1  sticky; captured frame length ≠ N
- o_ovf  out  1  sticky; a frame start was seen while in READOUT

## Operation
- Frame tracking: an sof flag is set by reset and by every accepted beat with tlast. It is cleared by any other accepted beat. This tracking runs in all states.
- FSM states: IDLE, ARMED, CAPTURE, READOUT. Reset enters IDLE.
- IDLE: on i_arm, clear o_len_err and o_ovf, then go to ARMED. i_arm in any other state is ignored.
- ARMED: the first accepted beat with sof=1 is written to address 0. On that beat, latch o_blk_exp and go to CAPTURE. Beats with sof=0 are dropped.
- CAPTURE: each accepted beat is written at wr_addr+1.
  - Capture ends on the beat with tlast, or on the beat written to address N-1, whichever comes first.
  - If tlast arrives at an address < N-1, set o_len_err. Readout then still covers N beats, and the unwritten tail holds stale data.
  - If address N-1 is written without tlast, set o_len_err.
  - After capture ends, go to READOUT.
- READOUT: stream addresses 0..N-1 in order. o_axi4s_data_tlast is high with address N-1.
  - The transfer of beat N-1 (tvalid & tready) returns the FSM to IDLE.
  - An accepted input beat with sof=1 during READOUT sets o_ovf. Input data is never written during READOUT.
- Buffer: a single-port-write / single-port-read RAM, N x 2*DATAOUT_WIDTH, with 1-cycle registered read.
- Replay pipeline: RAM read plus a 2-entry output skid.
  - No bubbles when i_axi4s_data_tready is held high.
  - While stalled, tdata and tlast are held stable.
  - tvalid never drops without a transfer.
- Output side ignores i_aclken; it advances every clock.

## Timing
- Reset values: all outputs 0; o_blk_exp 0; sof 1; addresses 0.
- Reset in any state aborts immediately. tvalid is 0 in the cycle after i_rst is sampled high.
- Capture-to-readout latency: first o_axi4s_data_tvalid rises 2 cycles after the cycle that accepted the final capture beat.
- Throughput: 1 beat per cycle in READOUT with tready=1. Total readout is exactly N transfers.
- o_busy rises in the cycle after i_arm. It falls in the cycle after the tlast transfer.
- Flag timing:
  - o_len_err asserts the cycle after the offending beat.
  - o_ovf asserts the cycle after the offending start beat.
  - Both stay set until the next accepted i_arm or i_rst.
- Simultaneous i_arm and final readout transfer: i_arm is ignored, and the FSM goes to IDLE.

## Test plan
- Normal frame (LOG2_FFT_LEN=3), with i_aclken pulsing 1-in-3:
  - Stimulus: arm, then drive 8 beats with data = address and tlast on beat 7; tready=1.
  - Required: 8 outputs with data 0..7, tlast only on beat 7, o_len_err=0, o_blk_exp = tuser[7:0] of beat 0.
- Arm mid-frame:
  - Stimulus: assert i_arm during beat 3 of a running frame.
  - Required: the remainder of that frame is dropped, and capture starts at the next frame's beat 0.
- Short and long frames:
  - Stimulus: a 5-beat frame with tlast on beat 4. Required: o_len_err=1 and readout of 8 beats, with 0..4 valid.
  - Stimulus: 8 beats with no tlast. Required: o_len_err=1 and readout of 8 beats.
- Back-pressure:
  - Stimulus: random tready at about 30% duty.
  - Required: exactly 8 transfers, in order, with no duplicates; tdata stable while tvalid & !tready.
- Overrun:
  - Stimulus: a second FFT frame arrives during READOUT with tready=0.
  - Required: o_ovf=1 and the replayed data is unchanged.
- Reset mid-READOUT:
  - Stimulus: assert i_rst at transfer 4.
  - Required: tvalid=0 next cycle and the FSM in IDLE; a subsequent arm and capture replays a fresh frame correctly.
